// File: rtl/lcd_controller.sv
// lcd_controller: FIFO-fed sequencer driving a character LCD with setup/pulse/hold/exec timing
module lcd_controller #(
    parameter int SETUP_CYCLES     = 2,
    parameter int PULSE_CYCLES     = 8,
    parameter int HOLD_CYCLES      = 2,
    parameter int EXEC_CYCLES      = 100,
    parameter int LONG_EXEC_CYCLES = 2000,
    parameter int FIFO_DEPTH       = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_rs,
    input  logic [7:0]                  req_data,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic [7:0]                  lcd_data,
    output logic [1:0]                  lcd_ctrl,
    output logic                        lcd_enable
);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int LW   = AW + 1;
    localparam int M0   = SETUP_CYCLES > PULSE_CYCLES ? SETUP_CYCLES : PULSE_CYCLES;
    localparam int M1   = M0 > HOLD_CYCLES ? M0 : HOLD_CYCLES;
    localparam int M2   = M1 > EXEC_CYCLES ? M1 : EXEC_CYCLES;
    localparam int MAXC = M2 > LONG_EXEC_CYCLES ? M2 : LONG_EXEC_CYCLES;
    localparam int CW   = $clog2(MAXC) + 1;

    typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, EXEC} state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [8:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [LW-1:0] r_level;
    logic          w_push;
    logic          w_pop;
    logic          w_long;
    logic          w_zero;
    logic [8:0]    w_head;

    assign req_ready  = r_level != LW'(FIFO_DEPTH);
    assign w_push     = req_valid && req_ready;
    assign w_pop      = (r_state == IDLE) && (r_level != '0);
    assign w_head     = r_mem[r_rd];
    assign w_zero     = r_cnt == '0;
    assign w_long     = !lcd_ctrl[1] && (lcd_data >= 8'h01) && (lcd_data <= 8'h03);
    assign busy       = (r_state != IDLE) || (r_level != '0);
    assign fifo_level = r_level;

    // FIFO storage; contents need no reset since level gates every read
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= {req_rs, req_data};
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + AW'(1);
            if (w_pop) r_rd <= r_rd + AW'(1);
            r_level <= r_level + LW'(w_push) - LW'(w_pop);
        end
    end

    // Transfer sequencer with registered LCD pins; latched rs/data also select the exec wait
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            lcd_data   <= 8'h00;
            lcd_ctrl   <= 2'b00;
            lcd_enable <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (w_pop) begin
                    lcd_data <= w_head[7:0];
                    lcd_ctrl <= {w_head[8], 1'b0};
                    r_cnt    <= CW'(SETUP_CYCLES - 1);
                    r_state  <= SETUP;
                end
                SETUP: if (w_zero) begin
                    lcd_enable <= 1'b1;
                    r_cnt      <= CW'(PULSE_CYCLES - 1);
                    r_state    <= PULSE;
                end else r_cnt <= r_cnt - CW'(1);
                PULSE: if (w_zero) begin
                    lcd_enable <= 1'b0;
                    r_cnt      <= CW'(HOLD_CYCLES - 1);
                    r_state    <= HOLD;
                end else r_cnt <= r_cnt - CW'(1);
                HOLD: if (w_zero) begin
                    r_cnt   <= w_long ? CW'(LONG_EXEC_CYCLES - 1) : CW'(EXEC_CYCLES - 1);
                    r_state <= EXEC;
                end else r_cnt <= r_cnt - CW'(1);
                EXEC: if (w_zero) r_state <= IDLE;
                      else r_cnt <= r_cnt - CW'(1);
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
